// File: rtl/aoc_types_pkg.sv
// aoc_types_pkg: shared sort encodings, entry typedefs and FSM states for the top-K sorter
package aoc_types_pkg;
   localparam bit SORT_ASC = 1'b0;
   localparam bit SORT_DESC = 1'b1;
   localparam int KEY_W_DEF = 40;
   localparam int PAY_W_DEF = 20;
   typedef logic [KEY_W_DEF-1:0] key_t;
   typedef logic [PAY_W_DEF-1:0] pay_t;
   typedef enum logic {ACCUM, DRAIN} state_t;
   typedef enum logic [1:0] {SEL_HOLD, SEL_NBR, SEL_IN} slot_sel_t;
endpackage

// File: rtl/topk_slot.sv
// topk_slot: one register slot of the sorted list with local compare and hold/neighbour/input mux
module topk_slot
   import aoc_types_pkg::*;
#(
   parameter int KEY_W = KEY_W_DEF,
   parameter int PAY_W = PAY_W_DEF,
   parameter bit SORT_OP = SORT_ASC
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             ins,
   input  logic             pop,
   input  logic             prev_ge,
   input  logic             nbr_vld,
   input  logic [KEY_W-1:0] nbr_key,
   input  logic [PAY_W-1:0] nbr_pay,
   input  logic [KEY_W-1:0] in_key,
   input  logic [PAY_W-1:0] in_pay,
   output logic             vld,
   output logic [KEY_W-1:0] key,
   output logic [PAY_W-1:0] pay,
   output logic             ge
);
   slot_sel_t sel;
   // ge means the new entry lands after this slot; ties keep the older entry ahead
   assign ge = vld && (SORT_OP ? key >= in_key : key <= in_key);
   always_comb sel = pop ? SEL_NBR : (!ins || ge) ? SEL_HOLD : prev_ge ? SEL_IN : SEL_NBR;
   always_ff @(posedge clk) begin
      if (!rst_n || clear) vld <= 1'b0;
      else if (sel == SEL_NBR) vld <= nbr_vld;
      else if (sel == SEL_IN) vld <= 1'b1;
   end
   always_ff @(posedge clk) begin
      if (sel == SEL_NBR) begin
         key <= nbr_key;
         pay <= nbr_pay;
      end else if (sel == SEL_IN) begin
         key <= in_key;
         pay <= in_pay;
      end
   end
endmodule

// File: rtl/topk_sorter.sv
// topk_sorter: keeps the best DEPTH key/payload entries in sorted order and drains them on request
module topk_sorter
   import aoc_types_pkg::*;
#(
   parameter int DEPTH = 1000,
   parameter int KEY_W = KEY_W_DEF,
   parameter int PAY_W = PAY_W_DEF,
   parameter bit SORT_OP = SORT_ASC
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic [KEY_W-1:0]           in_key,
   input  logic [PAY_W-1:0]           in_pay,
   input  logic                       in_vld,
   output logic                       in_rdy,
   input  logic                       drain,
   output logic [KEY_W-1:0]           out_key,
   output logic [PAY_W-1:0]           out_pay,
   output logic                       out_vld,
   input  logic                       out_rdy,
   output logic                       out_last,
   output logic                       drain_done,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int CW = $clog2(DEPTH+1);
   state_t state;
   logic [DEPTH+1:0][KEY_W-1:0] ek;
   logic [DEPTH+1:0][PAY_W-1:0] ep;
   logic [DEPTH+1:0] ev;
   logic [DEPTH:0] ge_e;
   logic ins, pop, accept;
   assign ek[0] = '0;
   assign ep[0] = '0;
   assign ev[0] = 1'b0;
   assign ek[DEPTH+1] = '0;
   assign ep[DEPTH+1] = '0;
   assign ev[DEPTH+1] = 1'b0;
   assign ge_e[0] = 1'b1;
   assign ins = state == ACCUM && in_vld;
   assign pop = state == DRAIN && count != '0 && out_rdy;
   // ge bits form a prefix, so the last one set means the list is full of better entries
   assign accept = ins && !ge_e[DEPTH];
   assign in_rdy = state == ACCUM;
   assign out_vld = state == DRAIN && count != '0;
   assign out_last = out_vld && count == CW'(1);
   assign out_key = ek[1];
   assign out_pay = ep[1];
   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      topk_slot #(.KEY_W(KEY_W), .PAY_W(PAY_W), .SORT_OP(SORT_OP)) u_slot (
         .clk(clk),
         .rst_n(rst_n),
         .clear(clear),
         .ins(ins),
         .pop(pop),
         .prev_ge(ge_e[i]),
         .nbr_vld(pop ? ev[i+2] : ev[i]),
         .nbr_key(pop ? ek[i+2] : ek[i]),
         .nbr_pay(pop ? ep[i+2] : ep[i]),
         .in_key(in_key),
         .in_pay(in_pay),
         .vld(ev[i+1]),
         .key(ek[i+1]),
         .pay(ep[i+1]),
         .ge(ge_e[i+1])
      );
   end
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         state <= ACCUM;
         count <= '0;
         drain_done <= 1'b0;
      end else begin
         drain_done <= 1'b0;
         if (state == ACCUM) begin
            if (accept && count != CW'(DEPTH)) count <= count + CW'(1);
            if (drain) begin
               if (count != '0 || accept) state <= DRAIN;
               else drain_done <= 1'b1;
            end
         end else if (pop) begin
            count <= count - CW'(1);
            if (count == CW'(1)) begin
               state <= ACCUM;
               drain_done <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_topk_sorter.sv
// tb_topk_sorter: directed checks of ascending and descending top-4 sorters fed the same stream
module tb_topk_sorter;
   logic clk = 1'b0;
   logic rst_n, clear, in_vld, drain, out_rdy;
   logic [7:0] in_key, in_pay;
   logic in_rdy_a, out_vld_a, out_last_a, done_a, in_rdy_b, out_vld_b, out_last_b, done_b;
   logic [7:0] key_a, pay_a, key_b, pay_b;
   logic [2:0] count_a, count_b;
   int errors = 0;
   int checks = 0;
   always #5 clk = ~clk;
   topk_sorter #(.DEPTH(4), .KEY_W(8), .PAY_W(8), .SORT_OP(1'b0)) dut_a (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_key(in_key), .in_pay(in_pay), .in_vld(in_vld),
      .in_rdy(in_rdy_a), .drain(drain), .out_key(key_a), .out_pay(pay_a), .out_vld(out_vld_a),
      .out_rdy(out_rdy), .out_last(out_last_a), .drain_done(done_a), .count(count_a));
   topk_sorter #(.DEPTH(4), .KEY_W(8), .PAY_W(8), .SORT_OP(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_key(in_key), .in_pay(in_pay), .in_vld(in_vld),
      .in_rdy(in_rdy_b), .drain(drain), .out_key(key_b), .out_pay(pay_b), .out_vld(out_vld_b),
      .out_rdy(out_rdy), .out_last(out_last_b), .drain_done(done_b), .count(count_b));
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic push(input logic [7:0] k, input logic [7:0] p);
      in_key = k;
      in_pay = p;
      in_vld = 1'b1;
      tick();
      in_vld = 1'b0;
   endtask
   task automatic start_drain();
      drain = 1'b1;
      tick();
      drain = 1'b0;
   endtask
   task automatic idle_state(input string tag);
      check({tag, " count_a"}, count_a, 0);
      check({tag, " count_b"}, count_b, 0);
      check({tag, " out_vld"}, {out_vld_a, out_vld_b}, 0);
      check({tag, " in_rdy"}, {in_rdy_a, in_rdy_b}, 2'b11);
      check({tag, " done"}, {done_a, done_b}, 0);
   endtask
   task automatic stream5();
      push(8'd7, 8'd7);
      push(8'd3, 8'd3);
      push(8'd9, 8'd9);
      push(8'd1, 8'd1);
      push(8'd5, 8'd5);
   endtask
   initial begin
      logic [7:0] asc [4] = '{8'd1, 8'd3, 8'd5, 8'd7};
      logic [7:0] dsc [4] = '{8'd9, 8'd7, 8'd5, 8'd3};
      logic [7:0] tie [4] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
      rst_n = 1'b0; clear = 1'b0; in_vld = 1'b0; drain = 1'b0; out_rdy = 1'b0;
      in_key = '0; in_pay = '0;
      tick();
      tick();
      rst_n = 1'b1;
      idle_state("reset");
      check("reset out_last", {out_last_a, out_last_b}, 0);
      stream5();
      check("fill count_a", count_a, 4);
      check("fill count_b", count_b, 4);
      out_rdy = 1'b1;
      start_drain();
      check("drain in_rdy", {in_rdy_a, in_rdy_b}, 0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("asc key %0d", i), key_a, asc[i]);
         check($sformatf("dsc key %0d", i), key_b, dsc[i]);
         check($sformatf("asc pay %0d", i), pay_a, asc[i]);
         check($sformatf("vld %0d", i), {out_vld_a, out_vld_b}, 2'b11);
         check($sformatf("last %0d", i), {out_last_a, out_last_b}, (i == 3) ? 2'b11 : 2'b00);
         check($sformatf("done early %0d", i), {done_a, done_b}, 0);
         tick();
      end
      check("drain done", {done_a, done_b}, 2'b11);
      check("drain end vld", {out_vld_a, out_vld_b}, 0);
      tick();
      check("done one cycle", {done_a, done_b}, 0);
      for (int i = 0; i < 5; i++) push(8'd4, 8'h0A + 8'(i));
      check("tie count", count_a, 4);
      start_drain();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("tie pay_a %0d", i), pay_a, tie[i]);
         check($sformatf("tie pay_b %0d", i), pay_b, tie[i]);
         tick();
      end
      tick();
      stream5();
      start_drain();
      check("bp head0", key_a, 1);
      tick();
      check("bp head1", key_a, 3);
      tick();
      out_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp key_a", key_a, 5);
         check("bp key_b", key_b, 5);
         check("bp pay_a", pay_a, 5);
         check("bp last", {out_last_a, out_last_b}, 0);
         check("bp count", count_a, 2);
         check("bp in_rdy", {in_rdy_a, in_rdy_b}, 0);
      end
      out_rdy = 1'b1;
      tick();
      check("bp tail", key_a, 7);
      check("bp tail last", out_last_a, 1);
      tick();
      check("bp done", done_a, 1);
      tick();
      start_drain();
      check("empty drain done", {done_a, done_b}, 2'b11);
      check("empty drain vld", {out_vld_a, out_vld_b}, 0);
      check("empty drain in_rdy", {in_rdy_a, in_rdy_b}, 2'b11);
      tick();
      check("empty done pulse", {done_a, done_b}, 0);
      check("empty vld later", {out_vld_a, out_vld_b}, 0);
      for (int r = 0; r < 2; r++) begin
         push(8'd7, 8'd7);
         push(8'd3, 8'd3);
         push(8'd9, 8'd9);
         push(8'd1, 8'd1);
         start_drain();
         tick();
         tick();
         out_rdy = 1'b0;
         check($sformatf("mid head %0d", r), key_a, 7);
         if (r == 0) clear = 1'b1;
         else rst_n = 1'b0;
         tick();
         clear = 1'b0;
         rst_n = 1'b1;
         idle_state($sformatf("flush %0d", r));
         tick();
         check($sformatf("flush no done %0d", r), {done_a, done_b}, 0);
         in_key = 8'd2;
         in_pay = 8'h22;
         in_vld = 1'b1;
         if (r == 1) drain = 1'b1;
         tick();
         in_vld = 1'b0;
         drain = 1'b0;
         if (r == 0) start_drain();
         check($sformatf("single key %0d", r), {key_a, key_b}, 16'h0202);
         check($sformatf("single pay %0d", r), pay_a, 8'h22);
         check($sformatf("single last %0d", r), {out_last_a, out_last_b}, 2'b11);
         out_rdy = 1'b1;
         tick();
         check($sformatf("single done %0d", r), {done_a, done_b}, 2'b11);
         tick();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/topk_sorter.md
Name: topk_sorter

Overview:
Parametrised successor to the insertion sorter chain. It holds the best DEPTH entries, each a key plus a payload, from an input stream. Entries are kept in ascending or descending key order, selectable at elaboration. On command the block drains its contents in sorted order over a valid/ready output handshake. It sits between the distance generator and the network LUT: keys are distances and payloads are point-index pairs.

Parameters:
DEPTH, 1000, number of retained entries (K of top-K), must be >= 1
KEY_W, 40, key width (squared distance)
PAY_W, 20, payload width (two point indices)
SORT_OP, 0, 0 = keep smallest and drain ascending; 1 = keep largest and drain descending

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
clear  input  1  synchronous flush: empties the list and returns to ACCUM
in_key  input  KEY_W  key of the candidate entry
in_pay  input  PAY_W  payload of the candidate entry
in_vld  input  1  candidate valid
in_rdy  output  1  candidate accepted when in_vld & in_rdy
drain  input  1  request to stream out the contents (sampled in ACCUM only)
out_key  output  KEY_W  head entry key
out_pay  output  PAY_W  head entry payload
out_vld  output  1  head entry valid
out_rdy  input  1  consumer ready
out_last  output  1  current output is the final entry
drain_done  output  1  one-cycle pulse when the drain completes
count  output  $clog2(DEPTH+1)  number of occupied entries

Behaviour:
- Reset (rst_n=0 at a clk edge): state ACCUM; count=0; all slot-valid bits 0; in_rdy=1; out_vld=0; out_last=0; drain_done=0. Key and payload storage are don't-care.
- States:
  - ACCUM: in_rdy=1, out_vld=0.
  - DRAIN: in_rdy=0, out_vld=(count!=0).
- Priority: rst_n, then clear, then normal operation. clear in any state: count=0, state ACCUM, no drain_done pulse.
- Insertion (ACCUM, in_vld=1):
  - Compare in parallel against all slots.
  - Position p = number of valid slots s with key[s] <= in_key (SORT_OP=0) or key[s] >= in_key (SORT_OP=1).
  - Ties: the new entry goes after existing equal keys, so ordering is stable and the earlier arrival wins eviction.
  - If p < DEPTH: slots p..DEPTH-2 shift down by one, the new entry is written to slot p, and count increments, saturating at DEPTH. When full, the old slot DEPTH-1 is evicted.
  - If p == DEPTH (list full and the candidate is not better): the candidate is dropped silently.
  - Single-cycle insert; the result is visible in count and storage the cycle after acceptance.
- Drain entry: drain=1 in ACCUM moves state to DRAIN on the next edge.
  - If in_vld is also 1 in that cycle, the candidate is accepted first and is included in the drain.
  - If count==0 at that point, the block stays in ACCUM and drain_done pulses the next cycle.
- DRAIN:
  - out_key/out_pay = slot 0, driven directly from storage, so out_vld rises the cycle after drain.
  - out_last = (count==1).
  - On out_vld & out_rdy: all slots shift up by one and count decrements.
  - While out_vld & !out_rdy, out_key/out_pay/out_last must stay stable.
  - After the handshake that takes count from 1 to 0: state returns to ACCUM on that edge, and drain_done=1 for exactly the following cycle.
  - drain is ignored while in DRAIN.
- Widths: key compare is unsigned, KEY_W bits. count never exceeds DEPTH.
- Storage must be register-based; the parallel compare plus shift must close timing in one cycle at the target DEPTH.

Decomposition:
- aoc_types_pkg holds:
  - the sort_op encoding constants
  - a parametrisable entry struct, or a KEY_W/PAY_W-based key/payload typedef, replacing direct use of conn_t
  - the state enum {ACCUM, DRAIN}
- One sub-module, topk_slot, instantiated DEPTH times. Each slot holds its valid bit, key and payload, and contains:
  - a local compare (is my key better than or equal to the incoming key)
  - a three-way next-value mux: hold / take neighbour above / take input.
- The top level owns the FSM, count, prefix-derived insert position and the output logic.

Test Plan:
1. DEPTH=4, SORT_OP=0; insert keys 7,3,9,1,5 -> count=4, slots hold 1,3,5,7 (9 evicted); drain with out_rdy=1 -> outputs 1,3,5,7 on consecutive cycles, out_last only on 7, drain_done pulse the cycle after.
2. DEPTH=4, SORT_OP=1; same stream -> drain outputs 9,7,5,3.
3. DEPTH=4; five entries all key=4 with payloads 0xA,0xB,0xC,0xD,0xE -> drain payloads 0xA,0xB,0xC,0xD; 0xE dropped; count stays 4.
4. Backpressure: during drain, hold out_rdy low for 3 cycles mid-stream -> out_key/out_pay/out_last unchanged and count unchanged; in_rdy=0 throughout DRAIN.
5. drain asserted with count=0 -> out_vld never rises, drain_done=1 exactly one cycle later, in_rdy stays 1.
6. Mid-drain, after 2 of 4 entries: assert clear (and separately rst_n=0) -> next cycle count=0, out_vld=0, in_rdy=1, no drain_done; a fresh insert of key 2 then drains as a single entry with out_last=1.
